bcd_scan_display: RTL and testbench

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

---
 rtl/bcd_scan_display_pkg.sv | 34 +++
 rtl/bcd_scan_display_bcd_to_seg.sv | 27 ++
 rtl/bcd_scan_display.sv | 136 +++++++++++++
 tb/tb_bcd_scan_display.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed four-digit BCD display.
package bcd_scan_display_pkg;

    // Number of multiplexed digits.
    localparam int NDIG = 4;

    // Drive level that lights a segment or enables a digit (active-low).
    localparam logic LED_ON = 1'b0;

    // Active-low seven-segment patterns, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All digit enables released.
    localparam logic [3:0] AN_OFF = 4'hF;

    // Digit-enable pattern that turns on only the digit at idx.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return (LED_ON == 1'b0) ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/bcd_scan_display_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Map one BCD digit onto its segment pattern.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed BCD display driver with snapshot register,
// leading-zero blanking, anti-ghosting dead cycle and invalid-code flag.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        invalid
);

    // Prescaler is wide enough to hold SCAN_DIV-1 without truncation.
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [15:0]   snap_r;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          invalid_r;

    logic          tick_s;
    logic [3:0]    digit_s;
    logic [3:0]    zero_above_s;
    logic          blank_s;
    logic [6:0]    dec_seg_s;
    logic [6:0]    seg_next_s;
    logic [3:0]    an_next_s;
    logic          invalid_next_s;

    assign tick_s = (cnt_r == CNT_MAX);

    // Prescaler: counts 0..SCAN_DIV-1 and wraps; reset aborts the current slot.
    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Scan index: advances one digit per tick, wrapping 3 -> 0.
    always_ff @(posedge clk) begin
        if (!clear) begin
            idx_r <= 2'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Snapshot register: the display never looks at bcd_in directly.
    always_ff @(posedge clk) begin
        if (!clear) begin
            snap_r <= 16'h0000;
        end else if (load) begin
            snap_r <= bcd_in;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Select the snapshot digit addressed by the scan index.
    always_comb begin
        digit_s = 4'h0;
        case (idx_r)
            2'd0:    digit_s = snap_r[3:0];
            2'd1:    digit_s = snap_r[7:4];
            2'd2:    digit_s = snap_r[11:8];
            2'd3:    digit_s = snap_r[15:12];
            default: digit_s = 4'h0;
        endcase
    end

    // Leading-zero chain: bit k set when digit k and every higher digit are zero;
    // dash codes are non-zero, and the units digit is never blanked.
    always_comb begin
        zero_above_s    = 4'b0000;
        zero_above_s[3] = (snap_r[15:12] == 4'h0);
        zero_above_s[2] = zero_above_s[3] && (snap_r[11:8] == 4'h0);
        zero_above_s[1] = zero_above_s[2] && (snap_r[7:4] == 4'h0);
        zero_above_s[0] = 1'b0;
        blank_s         = blank_lz && zero_above_s[idx_r];
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_s),
        .seg (dec_seg_s)
    );

    // Next output values: dead cycle at the start of every slot, otherwise one digit on.
    always_comb begin
        seg_next_s = blank_s ? SEG_BLANK : dec_seg_s;
        if (cnt_r == '0) begin
            an_next_s = AN_OFF;
        end else begin
            an_next_s = an_select(idx_r);
        end
        invalid_next_s = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (snap_r[4*k +: 4] > 4'd9) begin
                invalid_next_s = 1'b1;
            end else begin
                invalid_next_s = invalid_next_s;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!clear) begin
            seg_r     <= SEG_BLANK;
            an_r      <= AN_OFF;
            invalid_r <= 1'b0;
        end else begin
            seg_r     <= seg_next_s;
            an_r      <= an_next_s;
            invalid_r <= invalid_next_s;
        end
    end

    assign seg     = seg_r;
    assign an      = an_r;
    assign invalid = invalid_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with SCAN_DIV = 4.
module tb_bcd_scan_display;

    logic        clk;
    logic        clear;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        invalid;

    int          tests;
    int          fails;
    int          ecnt;      // edges since reset release (0 while clear is low)
    logic [6:0]  exp_seg [4];
    logic        exp_inv;

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (!clear) ecnt = 0;
        else        ecnt++;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run n cycles, checking an/seg/invalid against slot position and expected table.
    task automatic run(input int n);
        int c;
        int s;
        logic [3:0] ea;
        for (int i = 0; i < n; i++) begin
            step();
            c  = (ecnt - 1) % 4;
            s  = ((ecnt - 1) / 4) % 4;
            ea = ~(4'b0001 << s);
            if (c == 0) begin
                chk("an_dead", {4'h0, an}, 8'h0F);
            end else begin
                chk("an_slot", {4'h0, an}, {4'h0, ea});
                chk("seg_slot", {1'b0, seg}, {1'b0, exp_seg[s]});
            end
            chk("invalid", {7'h0, invalid}, {7'h0, exp_inv});
        end
    endtask

    task automatic set_exp(input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0, input logic inv);
        exp_seg[3] = d3;
        exp_seg[2] = d2;
        exp_seg[1] = d1;
        exp_seg[0] = d0;
        exp_inv    = inv;
    endtask

    initial begin
        tests = 0; fails = 0; ecnt = 0;
        clear = 1'b0; load = 1'b0; bcd_in = 16'h0000; blank_lz = 1'b0;

        // Reset held three cycles
        repeat (3) step();
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_inv", {7'h0, invalid}, 8'h00);

        // Release: dead cycle then digit 0
        clear = 1'b1;
        step();
        chk("rel_an1", {4'h0, an}, 8'h0F);
        step();
        chk("rel_an2", {4'h0, an}, 8'h0E);
        chk("rel_seg2", {1'b0, seg}, 8'h40);

        // 1234 without blanking, two full scan periods
        bcd_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        set_exp(7'h79, 7'h24, 7'h30, 7'h19, 1'b0);
        run(32);

        // 0070 with blanking, then blanking turned off
        bcd_in = 16'h0070; load = 1'b1; blank_lz = 1'b1;
        step();
        load = 1'b0;
        set_exp(7'h7F, 7'h7F, 7'h78, 7'h40, 1'b0);
        run(16);
        blank_lz = 1'b0;
        set_exp(7'h40, 7'h40, 7'h78, 7'h40, 1'b0);
        run(16);

        // A905: dash on digit 3, invalid one cycle after the load
        bcd_in = 16'hA905; load = 1'b1;
        step();
        load = 1'b0;
        chk("inv_load_edge", {7'h0, invalid}, 8'h00);
        set_exp(7'h3F, 7'h10, 7'h40, 7'h12, 1'b1);
        run(16);

        // 0905 clears invalid
        bcd_in = 16'h0905; load = 1'b1;
        step();
        load = 1'b0;
        chk("inv_still_old", {7'h0, invalid}, 8'h01);
        set_exp(7'h40, 7'h10, 7'h40, 7'h12, 1'b0);
        run(16);

        // 0A05 with blanking: dash counts as non-zero, so digit 1 zero is shown
        bcd_in = 16'h0A05; load = 1'b1; blank_lz = 1'b1;
        step();
        load = 1'b0;
        set_exp(7'h7F, 7'h3F, 7'h40, 7'h12, 1'b1);
        run(16);
        blank_lz = 1'b0;

        // Load coinciding with a tick, then bcd_in changes without load
        for (int k = 0; k < 4 && (ecnt % 4) != 3; k++) step();
        bcd_in = 16'h4321; load = 1'b1;
        step();
        load = 1'b0; bcd_in = 16'h9999;
        set_exp(7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
        run(8);
        bcd_in = 16'h8888;
        run(8);

        // Repeated load of unchanged data is a no-op
        bcd_in = 16'h4321; load = 1'b1;
        run(8);
        load = 1'b0;

        // Reset mid-slot 2 with a load attempt that must be ignored
        for (int k = 0; k < 16 && (ecnt % 16) != 10; k++) step();
        clear = 1'b0; load = 1'b1; bcd_in = 16'h5555;
        step();
        chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
        chk("mid_rst_an", {4'h0, an}, 8'h0F);
        chk("mid_rst_inv", {7'h0, invalid}, 8'h00);
        clear = 1'b1; load = 1'b0;
        set_exp(7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        run(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
